// File: rtl/instr_mem_loader_if.sv
// Loader bus bundle: inbound program byte stream (valid/ready) plus the
// instruction-memory write port driven by the loader.
interface instr_mem_loader_if #(
    parameter int ADDR_W = 7
);
    // A byte transfers on a rising edge where In_Valid && In_Ready; the
    // source holds In_Byte stable while In_Valid is high and not yet accepted.
    logic [7:0]        In_Byte;
    logic              In_Valid;
    logic              In_Ready;
    logic              I_wr;
    logic [ADDR_W-1:0] I_addr;
    logic [15:0]       I_data;

    modport slave (
        input  In_Byte, In_Valid,
        output In_Ready, I_wr, I_addr, I_data
    );

    modport master (
        output In_Byte, In_Valid,
        input  In_Ready, I_wr, I_addr, I_data
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Loads a big-endian 16-bit program from a byte stream into instruction memory
// and holds the processor in reset until the halt word is stored. Optional macro: CHECKSUM_EN.
module instr_mem_loader #(
    parameter int          ADDR_W    = 7,
    parameter logic [15:0] HALT_WORD = 16'h5000
) (
    input  logic                Clock,
    input  logic                ResetN,
    input  logic                Start,
    instr_mem_loader_if.slave   bus,
    output logic                Cpu_ResetN,
    output logic                Busy,
    output logic                Done,
    output logic                Error,
    output logic [ADDR_W:0]     Word_Count,
    output logic [2:0]          Dbg_State
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_HI = 3'd1,
        S_WAIT_LO = 3'd2,
        S_WRITE   = 3'd3,
`ifdef CHECKSUM_EN
        S_CHK     = 3'd4,
`endif
        S_RUN     = 3'd5,
        S_ERROR   = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        hi_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [15:0]       wdata_q;
    logic [ADDR_W:0]   wc_q;
    logic              is_halt;
    logic              addr_full;

    // wdata_q holds the word being written while in WRITE.
    assign is_halt   = (wdata_q == HALT_WORD);
    assign addr_full = (addr_q == {ADDR_W{1'b1}});

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

`ifdef CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            sum_q <= 8'd0;
        end else if ((state_q == S_IDLE || state_q == S_RUN || state_q == S_ERROR) && Start) begin
            sum_q <= 8'd0;
        end else if ((state_q == S_WAIT_HI || state_q == S_WAIT_LO) && bus.In_Valid) begin
            sum_q <= sum_q + bus.In_Byte;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_RUN, S_ERROR: if (Start) state_d = S_WAIT_HI;
            S_WAIT_HI: if (bus.In_Valid) state_d = S_WAIT_LO;
            S_WAIT_LO: if (bus.In_Valid) state_d = S_WRITE;
            S_WRITE: begin
                if (is_halt) begin
`ifdef CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_RUN;
`endif
                end else if (addr_full) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = S_WAIT_HI;
                end
            end
`ifdef CHECKSUM_EN
            S_CHK: if (bus.In_Valid) state_d = (bus.In_Byte == sum_q) ? S_RUN : S_ERROR;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            hi_q    <= 8'd0;
            addr_q  <= '0;
            waddr_q <= '0;
            wdata_q <= 16'd0;
            wc_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_RUN, S_ERROR: begin
                    if (Start) begin
                        addr_q <= '0;
                        wc_q   <= '0;
                    end
                end
                S_WAIT_HI: if (bus.In_Valid) hi_q <= bus.In_Byte;
                S_WAIT_LO: begin
                    // Capture address and word one cycle ahead so the write port is registered.
                    if (bus.In_Valid) begin
                        wdata_q <= {hi_q, bus.In_Byte};
                        waddr_q <= addr_q;
                    end
                end
                S_WRITE: begin
                    wc_q <= wc_q + 1'b1;
                    if (!is_halt && !addr_full) addr_q <= addr_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.In_Ready = 1'b0;
        bus.I_wr     = 1'b0;
        bus.I_addr   = waddr_q;
        bus.I_data   = wdata_q;
        Busy         = 1'b0;
        Done         = 1'b0;
        Error        = 1'b0;
        Cpu_ResetN   = 1'b0;
        Word_Count   = wc_q;
        Dbg_State    = state_q;
        case (state_q)
            S_WAIT_HI, S_WAIT_LO: begin
                bus.In_Ready = 1'b1;
                Busy         = 1'b1;
            end
            S_WRITE: begin
                bus.I_wr = 1'b1;
                Busy     = 1'b1;
            end
`ifdef CHECKSUM_EN
            S_CHK: begin
                bus.In_Ready = 1'b1;
                Busy         = 1'b1;
            end
`endif
            S_RUN: begin
                Done       = 1'b1;
                Cpu_ResetN = 1'b1;
            end
            S_ERROR: Error = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a 128-word instance and a 4-word
// instance share the byte stream; each has its own Start and write scoreboard.
module tb_instr_mem_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start_m = 1'b0;
    logic       start_s = 1'b0;
    logic [7:0] in_byte = 8'd0;
    logic       in_valid = 1'b0;

    instr_mem_loader_if #(.ADDR_W(7)) m_if ();
    instr_mem_loader_if #(.ADDR_W(2)) s_if ();
    assign m_if.In_Byte  = in_byte;
    assign m_if.In_Valid = in_valid;
    assign s_if.In_Byte  = in_byte;
    assign s_if.In_Valid = in_valid;

    logic       m_cpu, m_busy, m_done, m_err;
    logic [7:0] m_wc;
    logic [2:0] m_dbg;
    logic       s_cpu, s_busy, s_done, s_err;
    logic [2:0] s_wc;
    logic [2:0] s_dbg;

    instr_mem_loader #(.ADDR_W(7)) u_main (
        .Clock(clk), .ResetN(rst_n), .Start(start_m), .bus(m_if),
        .Cpu_ResetN(m_cpu), .Busy(m_busy), .Done(m_done), .Error(m_err),
        .Word_Count(m_wc), .Dbg_State(m_dbg)
    );

    instr_mem_loader #(.ADDR_W(2)) u_small (
        .Clock(clk), .ResetN(rst_n), .Start(start_s), .bus(s_if),
        .Cpu_ResetN(s_cpu), .Busy(s_busy), .Done(s_done), .Error(s_err),
        .Word_Count(s_wc), .Dbg_State(s_dbg)
    );

    int checks = 0;
    int errors = 0;
    int cur_sel = 0;
    bit load_bad;

    logic       rdy_x, busy_x, cpu_x, done_x, err_x;
    logic [7:0] wc_x;
    assign rdy_x  = (cur_sel == 1) ? s_if.In_Ready : m_if.In_Ready;
    assign busy_x = (cur_sel == 1) ? s_busy : m_busy;
    assign cpu_x  = (cur_sel == 1) ? s_cpu  : m_cpu;
    assign done_x = (cur_sel == 1) ? s_done : m_done;
    assign err_x  = (cur_sel == 1) ? s_err  : m_err;
    assign wc_x   = (cur_sel == 1) ? {5'd0, s_wc} : m_wc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboards: {addr (7 bits, zero-extended), data}
    logic [22:0] exp_q[$];
    logic [22:0] exp_small_q[$];
    logic [22:0] e_m, e_s;

    always @(negedge clk) begin
        if (m_if.I_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL main_write_unexpected: got %0h expected none", {m_if.I_addr, m_if.I_data});
            end else begin
                e_m = exp_q.pop_front();
                check("main_write", {m_if.I_addr, m_if.I_data}, {9'd0, e_m});
            end
        end
        if (s_if.I_wr === 1'b1) begin
            if (exp_small_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL small_write_unexpected: got %0h expected none", {s_if.I_addr, s_if.I_data});
            end else begin
                e_s = exp_small_q.pop_front();
                check("small_write", {5'd0, s_if.I_addr, s_if.I_data}, {9'd0, e_s});
            end
        end
    end

    typedef struct {
        int          sel;
        int          n;
        logic [63:0] bytes;
        int          gap;
        logic        exp_done;
        logic        exp_err;
        logic [7:0]  exp_wc;
    } vec_t;

    vec_t vecs[6];

    task automatic pulse_start(input int sel);
        @(posedge clk); #1;
        if (sel == 1) start_s = 1'b1; else start_m = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        start_m = 1'b0;
        check("start_cpu_resetn", {31'd0, cpu_x}, 32'd0);
        check("start_busy", {31'd0, busy_x}, 32'd1);
        check("start_word_count", {24'd0, wc_x}, 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got;
        repeat (gap) begin
            @(negedge clk);
            if (!(busy_x === 1'b1 && cpu_x === 1'b0)) load_bad = 1'b1;
            @(posedge clk); #1;
        end
        in_byte  = b;
        in_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!(busy_x === 1'b1 && cpu_x === 1'b0)) load_bad = 1'b1;
            if (rdy_x === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL byte_accept_timeout: got ready=0 expected ready=1 for byte %0h", b);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy_x !== 1'b1) begin
                idle = 1'b1;
                break;
            end
        end
        if (!idle) begin
            checks++; errors++;
            $display("FAIL load_end_timeout: got busy=1 expected busy=0");
        end
    endtask

    task automatic run_vector(input vec_t v);
        logic [15:0] word;
        logic [7:0]  sum;
        cur_sel  = v.sel;
        pulse_start(v.sel);
        load_bad = 1'b0;
        sum      = 8'd0;
        for (int w = 0; w < v.n / 2; w++) begin
            word = v.bytes[63 - 16*w -: 16];
            if (v.sel == 1) exp_small_q.push_back({w[6:0], word});
            else            exp_q.push_back({w[6:0], word});
        end
        for (int i = 0; i < v.n; i++) begin
            sum = sum + v.bytes[63 - 8*i -: 8];
            send_byte(v.bytes[63 - 8*i -: 8], v.gap);
        end
`ifdef CHECKSUM_EN
        if (v.exp_done) send_byte(sum, v.gap);
`endif
        wait_idle();
        check("done", {31'd0, done_x}, {31'd0, v.exp_done});
        check("error", {31'd0, err_x}, {31'd0, v.exp_err});
        check("cpu_resetn", {31'd0, cpu_x}, {31'd0, v.exp_done});
        check("word_count", {24'd0, wc_x}, {24'd0, v.exp_wc});
        check("in_ready_after_load", {31'd0, rdy_x}, 32'd0);
        check("busy_low_reset_during_load", {31'd0, load_bad}, 32'd0);
        check("writes_pending", exp_q.size() + exp_small_q.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_i_wr"}, {31'd0, m_if.I_wr}, 32'd0);
        check({tag, "_i_addr"}, {25'd0, m_if.I_addr}, 32'd0);
        check({tag, "_i_data"}, {16'd0, m_if.I_data}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, m_if.In_Ready}, 32'd0);
        check({tag, "_flags"}, {28'd0, m_cpu, m_busy, m_done, m_err}, 32'd0);
        check({tag, "_word_count"}, {24'd0, m_wc}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{sel: 0, n: 4, bytes: 64'h2001_5000_0000_0000, gap: 0, exp_done: 1'b1, exp_err: 1'b0, exp_wc: 8'd2};
        vecs[1] = '{sel: 0, n: 4, bytes: 64'h2001_5000_0000_0000, gap: 5, exp_done: 1'b1, exp_err: 1'b0, exp_wc: 8'd2};
        vecs[2] = '{sel: 0, n: 2, bytes: 64'h5000_0000_0000_0000, gap: 0, exp_done: 1'b1, exp_err: 1'b0, exp_wc: 8'd1};
        vecs[3] = '{sel: 0, n: 6, bytes: 64'h1234_ABCD_5000_0000, gap: 1, exp_done: 1'b1, exp_err: 1'b0, exp_wc: 8'd3};
        vecs[4] = '{sel: 1, n: 8, bytes: 64'h1122_3344_5566_7788, gap: 0, exp_done: 1'b0, exp_err: 1'b1, exp_wc: 8'd4};
        vecs[5] = '{sel: 1, n: 2, bytes: 64'h5000_0000_0000_0000, gap: 2, exp_done: 1'b1, exp_err: 1'b0, exp_wc: 8'd1};

        // Reset state
        #3;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {28'd0, m_cpu, m_busy, m_done, m_err}, 32'd0);

        for (int k = 0; k < 6; k++) run_vector(vecs[k]);

        // Reset mid-load after three bytes, then a clean reload from address 0
        cur_sel = 0;
        pulse_start(0);
        exp_q.push_back({7'd0, 16'h2001});
        send_byte(8'h20, 0);
        send_byte(8'h01, 0);
        send_byte(8'h50, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midload_reset");
        check("midload_writes_pending", exp_q.size(), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_vector(vecs[0]);

`ifdef CHECKSUM_EN
        // Wrong check byte: 20+01+50+00 = 71, send 72
        cur_sel = 0;
        pulse_start(0);
        exp_q.push_back({7'd0, 16'h2001});
        exp_q.push_back({7'd1, 16'h5000});
        send_byte(8'h20, 0);
        send_byte(8'h01, 0);
        send_byte(8'h50, 0);
        send_byte(8'h00, 0);
        send_byte(8'h72, 0);
        wait_idle();
        check("chk_bad_error", {31'd0, m_err}, 32'd1);
        check("chk_bad_done", {31'd0, m_done}, 32'd0);
        check("chk_bad_cpu_resetn", {31'd0, m_cpu}, 32'd0);
        check("chk_bad_word_count", {24'd0, m_wc}, 32'd2);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
